// File: rtl/bus_interconnect_if.sv
// Bus and slave-fan-out signal bundle around the address-decoding interconnect.
// The fabric takes the slave modport; the arbiter/slave environment takes master.
interface bus_interconnect_if;
    logic [31:0]  bus_addr;
    logic [31:0]  bus_wdata;
    logic [3:0]   bus_wstrb;
    logic         bus_write;
    logic         bus_enable;
    logic [31:0]  bus_rdata;
    logic         bus_ready;
    logic         bus_err;
    logic [31:0]  s_addr;
    logic [31:0]  s_wdata;
    logic [3:0]   s_wstrb;
    logic         s_write;
    logic [3:0]   s_enable;
    logic [127:0] s_rdata;
    logic [3:0]   s_ready;

    modport slave (
        input  bus_addr, bus_wdata, bus_wstrb, bus_write, bus_enable, s_rdata, s_ready,
        output bus_rdata, bus_ready, bus_err, s_addr, s_wdata, s_wstrb, s_write, s_enable
    );

    modport master (
        output bus_addr, bus_wdata, bus_wstrb, bus_write, bus_enable, s_rdata, s_ready,
        input  bus_rdata, bus_ready, bus_err, s_addr, s_wdata, s_wstrb, s_write, s_enable
    );
endinterface

// File: rtl/bus_interconnect.sv
// Routes the arbitrated request to one of four slaves, holds the route for the whole
// transaction, and answers unmapped or stalled accesses with a one-cycle error response.
module bus_interconnect #(
    parameter logic [31:0] S0_BASE   = 32'h0000_0000,
    parameter logic [31:0] S0_MASK   = 32'hFFFF_0000,
    parameter logic [31:0] S1_BASE   = 32'h4000_0000,
    parameter logic [31:0] S1_MASK   = 32'hFFFF_F000,
    parameter logic [31:0] S2_BASE   = 32'h4000_1000,
    parameter logic [31:0] S2_MASK   = 32'hFFFF_F000,
    parameter logic [31:0] S3_BASE   = 32'h4000_2000,
    parameter logic [31:0] S3_MASK   = 32'hFFFF_F000,
    parameter int          TIMEOUT   = 64,
    parameter logic [31:0] ERR_RDATA = 32'hDEAD_BEEF
) (
    input  logic               clk,
    input  logic               rst_n,
    bus_interconnect_if.slave  bus,
    output logic [7:0]         err_count,
    output logic [31:0]        err_addr
);

    typedef enum logic [1:0] {IDLE, BUSY, ERR} state_t;

    localparam logic [31:0] BASE [4] = '{S0_BASE, S1_BASE, S2_BASE, S3_BASE};
    localparam logic [31:0] MASK [4] = '{S0_MASK, S1_MASK, S2_MASK, S3_MASK};
    localparam logic [7:0]  TMO_LAST = 8'(TIMEOUT - 1);

    state_t      state_reg, state_next;
    logic [1:0]  sel_reg, sel_next;
    logic [7:0]  tmo_reg, tmo_next;
    logic [7:0]  err_count_reg;
    logic [31:0] err_addr_reg;

    logic [3:0]  hit;
    logic [1:0]  dec_idx;
    logic [3:0]  en_c;
    logic        ready_c;
    logic        err_c;
    logic [31:0] rdata_c;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_dec
            assign hit[gi] = (bus.bus_addr & MASK[gi]) == BASE[gi];
        end
    endgenerate

    // Scan from the top so the lowest matching slave wins on overlapping windows.
    always_comb begin
        dec_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (hit[i]) dec_idx = 2'(i);
        end
    end

    always_comb begin
        state_next = state_reg;
        sel_next   = sel_reg;
        tmo_next   = tmo_reg;
        en_c       = 4'b0000;
        ready_c    = 1'b0;
        err_c      = 1'b0;
        rdata_c    = 32'h0;
        case (state_reg)
            IDLE: begin
                if (bus.bus_enable) begin
                    if (|hit) begin
                        en_c = 4'b0001 << dec_idx;
                        if (bus.s_ready[dec_idx]) begin
                            ready_c = 1'b1;
                            rdata_c = bus.s_rdata[{dec_idx, 5'd0} +: 32];
                        end else begin
                            sel_next   = dec_idx;
                            tmo_next   = 8'd1;
                            state_next = BUSY;
                        end
                    end else begin
                        state_next = ERR;
                    end
                end
            end
            BUSY: begin
                en_c = {3'b000, bus.bus_enable} << sel_reg;
                if (!bus.bus_enable) begin
                    tmo_next   = 8'd0;
                    state_next = IDLE;
                end else if (bus.s_ready[sel_reg]) begin
                    ready_c    = 1'b1;
                    rdata_c    = bus.s_rdata[{sel_reg, 5'd0} +: 32];
                    tmo_next   = 8'd0;
                    state_next = IDLE;
                end else if (tmo_reg == TMO_LAST) begin
                    tmo_next   = 8'd0;
                    state_next = ERR;
                end else begin
                    tmo_next = tmo_reg + 8'd1;
                end
            end
            ERR: begin
                ready_c    = 1'b1;
                err_c      = 1'b1;
                rdata_c    = ERR_RDATA;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            sel_reg       <= 2'd0;
            tmo_reg       <= 8'd0;
            err_count_reg <= 8'd0;
            err_addr_reg  <= 32'h0;
        end else begin
            state_reg <= state_next;
            sel_reg   <= sel_next;
            tmo_reg   <= tmo_next;
            if (state_reg == ERR) begin
                err_addr_reg <= bus.bus_addr;
                if (err_count_reg != 8'hFF) err_count_reg <= err_count_reg + 8'd1;
            end
        end
    end

    // Outputs are forced low for the whole time reset is held, including the broadcasts.
    assign bus.s_enable  = rst_n ? en_c : 4'b0000;
    assign bus.bus_ready = rst_n & ready_c;
    assign bus.bus_err   = rst_n & err_c;
    assign bus.bus_rdata = rst_n ? rdata_c : 32'h0;
    assign bus.s_addr    = rst_n ? bus.bus_addr : 32'h0;
    assign bus.s_wdata   = rst_n ? bus.bus_wdata : 32'h0;
    assign bus.s_wstrb   = rst_n ? bus.bus_wstrb : 4'h0;
    assign bus.s_write   = rst_n & bus.bus_write;
    assign err_count     = err_count_reg;
    assign err_addr      = err_addr_reg;

endmodule

// File: tb/tb_bus_interconnect.sv
// Directed bench for bus_interconnect: expected responses are queued when a request
// is driven and popped when bus_ready is seen.
module tb_bus_interconnect;
    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  err_count;
    logic [31:0] err_addr;

    always #5 clk = ~clk;

    bus_interconnect_if bif();

    bus_interconnect #(.TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bif),
        .err_count (err_count),
        .err_addr  (err_addr)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    resp_t       sb[$];
    int          checks = 0;
    int          errors = 0;
    int          exp_err_cnt = 0;
    logic [31:0] exp_err_addr = 32'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // slv < 0 means miss; ready_after < 0 means the slave never answers.
    task automatic run_txn(input logic [31:0] addr, input logic wr, input int slv,
                           input int ready_after, input int exp_lat, input bit hold);
        logic [3:0]  exp_en;
        logic [31:0] wdata;
        resp_t       r;
        resp_t       got;
        int          cyc;
        bit          done;
        exp_en = (slv >= 0) ? (4'b0001 << slv) : 4'b0000;
        wdata  = $urandom;
        @(posedge clk); #1;
        bif.bus_addr   = addr;
        bif.bus_write  = wr;
        bif.bus_wdata  = wdata;
        bif.bus_wstrb  = 4'hF;
        bif.bus_enable = 1'b1;
        for (int i = 0; i < 4; i++) bif.s_rdata[32*i +: 32] = $urandom;
        bif.s_ready = ~exp_en | ((ready_after == 0) ? exp_en : 4'b0000);
        if (slv < 0 || ready_after < 0) begin
            r.rdata = 32'hDEAD_BEEF;
            r.err   = 1'b1;
        end else begin
            r.rdata = bif.s_rdata[32*slv +: 32];
            r.err   = 1'b0;
        end
        sb.push_back(r);
        done = 0;
        cyc  = 0;
        while (!done && cyc <= TIMEOUT + 4) begin
            @(negedge clk);
            if (bif.bus_ready) begin
                done = 1;
                got  = sb.pop_front();
                chk("latency", 32'(cyc), 32'(exp_lat));
                chk("rdata", bif.bus_rdata, got.rdata);
                chk("bus_err", {31'b0, bif.bus_err}, {31'b0, got.err});
                chk("s_enable_done", {28'b0, bif.s_enable}, {28'b0, (got.err ? 4'b0000 : exp_en)});
                chk("s_addr", bif.s_addr, addr);
                chk("s_wdata", bif.s_wdata, wdata);
                chk("s_write", {31'b0, bif.s_write}, {31'b0, wr});
                if (got.err) begin
                    if (exp_err_cnt < 255) exp_err_cnt++;
                    exp_err_addr = addr;
                end
                $display("txn addr=%h wr=%0d lat=%0d err=%0d rdata=%h", addr, wr, cyc,
                         bif.bus_err, bif.bus_rdata);
            end else begin
                chk("s_enable_wait", {28'b0, bif.s_enable}, {28'b0, exp_en});
                cyc++;
                @(posedge clk); #1;
                if (slv >= 0 && ready_after == cyc) bif.s_ready = bif.s_ready | exp_en;
            end
        end
        if (!done) begin
            chk("ready_bound", 32'd0, 32'd1);
            void'(sb.pop_front());
        end
        if (!hold) begin
            @(posedge clk); #1;
            bif.bus_enable = 1'b0;
            bif.s_ready    = 4'b0000;
            chk("err_count", {24'b0, err_count}, 32'(exp_err_cnt));
            chk("err_addr", err_addr, exp_err_addr);
            @(negedge clk);
            chk("ready_after_done", {31'b0, bif.bus_ready}, 32'd0);
        end
    endtask

    initial begin
        int rdy_seen;
        bif.bus_addr   = 32'h0000_0010;
        bif.bus_wdata  = 32'h0;
        bif.bus_wstrb  = 4'h0;
        bif.bus_write  = 1'b0;
        bif.bus_enable = 1'b1;
        bif.s_rdata    = '1;
        bif.s_ready    = 4'hF;

        // Reset: request present but everything must stay quiet.
        #12;
        chk("rst_s_enable", {28'b0, bif.s_enable}, 32'd0);
        chk("rst_ready", {31'b0, bif.bus_ready}, 32'd0);
        chk("rst_rdata", bif.bus_rdata, 32'd0);
        chk("rst_s_addr", bif.s_addr, 32'd0);
        chk("rst_err_count", {24'b0, err_count}, 32'd0);
        chk("rst_err_addr", err_addr, 32'd0);
        bif.bus_enable = 1'b0;
        bif.s_ready    = 4'h0;
        #11 rst_n = 1'b1;

        run_txn(32'h0000_0010, 1'b0, 0, 0, 0, 1'b0);              // zero-wait RAM read
        run_txn(32'h4000_1004, 1'b1, 2, 3, 3, 1'b0);              // timer write, 3 wait cycles
        run_txn(32'h8000_0000, 1'b0, -1, -1, 1, 1'b0);            // miss
        run_txn(32'h4000_0000, 1'b0, 1, -1, TIMEOUT, 1'b0);       // UART timeout
        run_txn(32'h4000_0008, 1'b0, 1, TIMEOUT-1, TIMEOUT-1, 1'b0); // ready on timeout cycle
        run_txn(32'h0000_FFFC, 1'b0, 0, 0, 0, 1'b1);              // back-to-back pair
        run_txn(32'h4000_2FFC, 1'b0, 3, 0, 0, 1'b0);
        run_txn(32'h0001_0000, 1'b1, -1, -1, 1, 1'b0);            // just above RAM window

        // Abort: arbiter releases the bus while BUSY on slave 1.
        @(posedge clk); #1;
        bif.bus_addr = 32'h4000_0004; bif.bus_enable = 1'b1; bif.s_ready = 4'b0000;
        @(negedge clk); chk("abort_en0", {28'b0, bif.s_enable}, 32'h2);
        @(posedge clk); #1;
        @(negedge clk); chk("abort_en1", {28'b0, bif.s_enable}, 32'h2);
        @(posedge clk); #1;
        @(posedge clk); #1; bif.bus_enable = 1'b0;
        @(negedge clk);
        chk("abort_en_drop", {28'b0, bif.s_enable}, 32'h0);
        rdy_seen = 0;
        for (int i = 0; i < TIMEOUT + 4; i++) begin
            if (bif.bus_ready) rdy_seen++;
            @(negedge clk);
        end
        chk("abort_no_ready", 32'(rdy_seen), 32'd0);
        chk("abort_err_count", {24'b0, err_count}, 32'(exp_err_cnt));
        $display("txn abort addr=40000004 ready_pulses=%0d", rdy_seen);

        // Saturation of the error counter.
        for (int n = 0; n < 260; n++) run_txn(32'h9000_0000 + 32'(n*4), 1'b0, -1, -1, 1, 1'b0);
        chk("err_count_sat", {24'b0, err_count}, 32'd255);

        // Asynchronous reset in the middle of a BUSY transaction.
        @(posedge clk); #1;
        bif.bus_addr = 32'h4000_1000; bif.bus_enable = 1'b1; bif.bus_write = 1'b0;
        bif.s_ready = 4'b0000;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk); chk("busy_before_rst", {28'b0, bif.s_enable}, 32'h4);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_s_enable", {28'b0, bif.s_enable}, 32'h0);
        chk("arst_ready", {31'b0, bif.bus_ready}, 32'd0);
        chk("arst_rdata", bif.bus_rdata, 32'd0);
        chk("arst_s_addr", bif.s_addr, 32'd0);
        chk("arst_err_count", {24'b0, err_count}, 32'd0);
        chk("arst_err_addr", err_addr, 32'd0);
        $display("txn async reset during BUSY addr=40001000");
        exp_err_cnt  = 0;
        exp_err_addr = 32'h0;
        bif.bus_enable = 1'b0;
        #3 rst_n = 1'b1;

        run_txn(32'h0000_0020, 1'b0, 0, 0, 0, 1'b0);
        run_txn(32'hC000_0000, 1'b0, -1, -1, 1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end
endmodule
